apple_shadow_write_queue: RTL
=============================

Name: apple_shadow_write_queue

Overview:
- Parametrised successor to the fixed-layout shadow-memory write path.
- Captures Apple II bus writes to the video windows $0400-$0BFF (text) and $2000-$9FFF (hires/VGC) and translates each into a bank-local byte address.
- Optional linearized (SHR) remap on non-main banks.
- Writes are queued in a FIFO and drained to a shared wide-word RAM port using a req/ack handshake, so slow or arbitrated video RAM never loses bus writes.

Parameters:
- NUM_BANKS, 2, number of shadow banks (0 = main, 1 = aux, >1 = extra VGC banks); must be 1..8.
- WORD_BYTES, 4, byte lanes per RAM word; must be 1, 2, 4 or 8.
- FIFO_DEPTH, 8, queue entries; must be a power of 2, at least 2.
- LINEARIZE_EN, 1, 1 = support linearize_i remap; 0 = linearize_i ignored.

Ports:
- clk_logic  in  1  single clock for all logic.
- system_reset  in  1  asynchronous, active-high reset.
- bus_addr_i  in  16  Apple II address.
- bus_data_i  in  8  write data.
- bus_wr_strobe_i  in  1  one-cycle qualified write strobe (rw_n low and data valid).
- bus_bank_i  in  BW=max(1,$clog2(NUM_BANKS))  target bank, already resolved upstream (aux/m2b0 decode).
- linearize_i  in  1  SHR linearize mode.
- mem_req_o  out  1  write request to RAM.
- mem_ack_i  in  1  RAM accepted current request.
- mem_bank_o  out  BW  bank of current request.
- mem_addr_o  out  16-$clog2(WORD_BYTES)  word address.
- mem_wdata_o  out  8*WORD_BYTES  bus_data replicated across all lanes.
- mem_be_o  out  WORD_BYTES  one-hot byte enable.
- fill_level_o  out  $clog2(FIFO_DEPTH)+1  entries queued.
- overflow_o  out  1  sticky flag: a write was dropped.
- clear_overflow_i  in  1  clears overflow_o.

Behaviour:
- Reset (asynchronous, active-high) sets FIFO empty, FSM to IDLE, and mem_req_o=0, mem_bank_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0, fill_level_o=0, overflow_o=0.
- Address decode (combinational, evaluated on the strobe):
  - $2000-$9FFF gives byte address B = addr-$2000 (range $0000-$7FFF).
  - $0400-$0BFF gives B = $8000 + (addr-$0400).
  - All other addresses are ignored: no push, no flag.
- Linearize remap: applies when LINEARIZE_EN=1, linearize_i=1, bank!=0 and the address is in the hires window. Then B = {1'b0, A[0], A[14:1]}, where A is the hires offset. Even bytes land in $0000-$3FFF, odd bytes in $4000-$7FFF. Text writes are never remapped.
- Bank index at or above NUM_BANKS: the write is dropped silently.
- Entry formation: the FIFO stores {bank, B, data}.
  - On issue: word address = B >> $clog2(WORD_BYTES).
  - mem_be_o = 1 << B[$clog2(WORD_BYTES)-1:0].
  - mem_wdata_o = data replicated across all lanes.
- Push rules:
  - A decoded strobe pushes at the clk_logic edge where it is sampled.
  - When full, the push is accepted only if a pop occurs in the same cycle. Otherwise the entry is dropped and overflow_o is set on the next edge.
  - A simultaneous set and clear_overflow_i leaves overflow_o = 1 (set wins).
- fill_level_o is registered: +1 on push, -1 on pop, unchanged on both together. It never exceeds FIFO_DEPTH.
- Drain FSM:
  - IDLE: if the FIFO is non-empty, load the head into the mem_* registers, set mem_req_o=1, go to REQ.
  - REQ: hold all mem_* outputs stable while mem_ack_i=0. When mem_ack_i=1: pop the head, clear mem_req_o, go to IDLE.
  - Ack may arrive in the same cycle req first goes high.
  - mem_* outputs other than mem_req_o keep their last value in IDLE.
  - mem_ack_i while IDLE is ignored.
- Latency: strobe sampled at edge k gives mem_req_o high after edge k+1 (empty queue, IDLE).
- Throughput: at most one transaction per 2 cycles, because of a mandatory IDLE cycle between requests.
- Ordering: strict FIFO order, no coalescing. Two writes to the same byte are both issued, in order.
- Reset asserted mid-REQ: the request is abandoned (mem_req_o drops asynchronously) and the queue contents are lost. The RAM side must treat req falling without an ack as a cancel.
- Pointer wrap-around uses natural $clog2(FIFO_DEPTH)-bit rollover. Full/empty are derived from fill_level, not from pointer equality.

Test Plan:
- Text write: strobe addr $0401, data $C1, bank 1, WORD_BYTES=4 -> mem_bank_o=1, mem_addr_o=$2000, mem_be_o=4'b0010, mem_wdata_o=$C1C1C1C1, req high one cycle after capture.
- Hires plus linearize: bank 1, linearize_i=1, writes $2000=$11 and $2001=$22 -> first word $0000 with be 0001; second word $1000 (byte $4000) with be 0001; order preserved. Same writes on bank 0 -> words $0000 and $0000 with be 0001 then 0010.
- Filtered addresses: strobes to $0000, $0C00, $A000 and $C030 -> no push, fill_level_o stays 0, overflow_o=0.
- Overflow: FIFO_DEPTH=8, mem_ack_i held 0, 10 strobes -> fill_level_o=8, overflow_o=1 after the 10th. Then assert clear_overflow_i together with an 11th strobe -> overflow_o stays 1. Then release ack -> exactly the first 8 data values drain in order.
- Full push with pop: queue full, ack coincides with a new strobe -> entry accepted, fill_level_o stays 8, overflow_o unchanged.
- Reset mid-request: req high, ack 0, 3 entries queued, pulse system_reset -> mem_req_o=0 immediately; after release fill_level_o=0; no request until a new strobe arrives.

Source files
------------

// File: rtl/apple_shadow_write_queue.sv
// Captures Apple II video-window bus writes, queues them and drains them to a wide-word RAM port.
// Latency: strobe at edge k -> mem_req_o after edge k+1; backpressure: mem_ack_i stalls drain, full queue drops and flags overflow.
module apple_shadow_write_queue #(
    parameter int NUM_BANKS    = 2,
    parameter int WORD_BYTES   = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int LINEARIZE_EN = 1,
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int LW = $clog2(WORD_BYTES),
    localparam int AW = 16 - LW,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int FW = PW + 1
) (
    input  logic                    clk_logic,
    input  logic                    system_reset,
    input  logic [15:0]             bus_addr_i,
    input  logic [7:0]              bus_data_i,
    input  logic                    bus_wr_strobe_i,
    input  logic [BW-1:0]           bus_bank_i,
    input  logic                    linearize_i,
    output logic                    mem_req_o,
    input  logic                    mem_ack_i,
    output logic [BW-1:0]           mem_bank_o,
    output logic [AW-1:0]           mem_addr_o,
    output logic [8*WORD_BYTES-1:0] mem_wdata_o,
    output logic [WORD_BYTES-1:0]   mem_be_o,
    output logic [FW-1:0]           fill_level_o,
    output logic                    overflow_o,
    input  logic                    clear_overflow_i
);

    generate
        if (NUM_BANKS < 1 || NUM_BANKS > 8)
            $error("NUM_BANKS must be 1..8");
        if (WORD_BYTES != 1 && WORD_BYTES != 2 && WORD_BYTES != 4 && WORD_BYTES != 8)
            $error("WORD_BYTES must be 1, 2, 4 or 8");
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
            $error("FIFO_DEPTH must be a power of 2, at least 2");
    endgenerate

    typedef struct packed {
        logic [BW-1:0] bank;
        logic [15:0]   byte_addr;
        logic [7:0]    data;
    } entry_t;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t                  state_q, state_d;
    entry_t                  fifo_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]           fill_q, fill_d;
    logic                    ovf_q, ovf_d;
    logic                    mem_req_q;
    logic [BW-1:0]           mem_bank_q;
    logic [AW-1:0]           mem_addr_q;
    logic [8*WORD_BYTES-1:0] mem_wdata_q;
    logic [WORD_BYTES-1:0]   mem_be_q;

    logic        dec_vld;
    logic [15:0] dec_byte;
    logic [15:0] hires_off;
    logic        bank_ok;
    logic        full, empty;
    logic        push_req, push_ok, drop, load, pop;
    entry_t      head;
    logic [15:0] head_lane;

    always_comb begin
        dec_vld   = 1'b0;
        dec_byte  = '0;
        hires_off = bus_addr_i - 16'h2000;
        if (bus_addr_i >= 16'h2000 && bus_addr_i <= 16'h9FFF) begin
            dec_vld = 1'b1;
            // SHR linearize: even bytes fill the lower 16K, odd bytes the upper 16K.
            if (LINEARIZE_EN != 0 && linearize_i && bus_bank_i != '0)
                dec_byte = {1'b0, hires_off[0], hires_off[14:1]};
            else
                dec_byte = hires_off;
        end else if (bus_addr_i >= 16'h0400 && bus_addr_i <= 16'h0BFF) begin
            dec_vld  = 1'b1;
            dec_byte = 16'h8000 + (bus_addr_i - 16'h0400);
        end
    end

    generate
        if (NUM_BANKS == (1 << BW)) begin : g_bank_full
            assign bank_ok = 1'b1;
        end else begin : g_bank_cmp
            assign bank_ok = (32'(bus_bank_i) < 32'(NUM_BANKS));
        end
    endgenerate

    assign full     = (fill_q == FW'(FIFO_DEPTH));
    assign empty    = (fill_q == '0);
    assign push_req = bus_wr_strobe_i & dec_vld & bank_ok;
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign head      = fifo_q[rd_ptr_q];
    assign head_lane = head.byte_addr & 16'(WORD_BYTES - 1);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fill_d = fill_q;
        case ({push_ok, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        // A new drop outranks a same-cycle clear.
        ovf_d = (ovf_q & ~clear_overflow_i) | drop;
    end

    // Storage needs no reset: occupancy is tracked by fill_q alone.
    always_ff @(posedge clk_logic) begin
        if (push_ok)
            fifo_q[wr_ptr_q] <= '{bank: bus_bank_i, byte_addr: dec_byte, data: bus_data_i};
    end

    always_ff @(posedge clk_logic or posedge system_reset) begin
        if (system_reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            ovf_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_bank_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            ovf_q   <= ovf_d;
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                mem_req_q <= 1'b0;
            end
            if (load) begin
                mem_req_q   <= 1'b1;
                mem_bank_q  <= head.bank;
                mem_addr_q  <= AW'(head.byte_addr >> LW);
                mem_wdata_q <= {WORD_BYTES{head.data}};
                mem_be_q    <= WORD_BYTES'(1) << head_lane;
            end
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_bank_o   = mem_bank_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_be_o     = mem_be_q;
    assign fill_level_o = fill_q;
    assign overflow_o   = ovf_q;

endmodule
